// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I/RV64I execute stage with registered single-cycle ops and
// bit-serial unsigned MUL/MULHU/DIVU/REMU. Define ALU_DIV_EN to build the divider.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13,
    OP_ILL   = 4'd14
  } op_e;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  state_e              state_r, state_nx_s;
  op_e                 dec_op_s, op_r;
  logic [SHW-1:0]      cnt_r;
  logic [2*XLEN-1:0]   wk_r, wk_nx_s, mul_step_s;
  logic [XLEN-1:0]     opnd_r;
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN-1:0]     alu_res_s, fin_res_s;
  logic [SHW-1:0]      shamt_s;
  logic                accept_s, is_mul_s, is_div_s, div0_s, is_iter_s;
  logic                in_ready_nx_s, out_valid_nx_s;
  logic                in_ready_r, out_valid_r, zero_r, illegal_r;
  logic [XLEN-1:0]     result_r;
`ifdef ALU_DIV_EN
  logic [XLEN:0]       div_sh_s, div_diff_s;
  logic [2*XLEN-1:0]   div_step_s;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;

  // Instruction decode from ALUOp/funct7/funct3 into an internal op code
  always_comb begin
    dec_op_s = OP_ILL;
    case (alu_op)
      2'b00: dec_op_s = OP_ADD;
      2'b01: dec_op_s = OP_SUB;
      2'b10: begin
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  dec_op_s = OP_ADD;
              3'b001:  dec_op_s = OP_SLL;
              3'b010:  dec_op_s = OP_SLT;
              3'b011:  dec_op_s = OP_SLTU;
              3'b100:  dec_op_s = OP_XOR;
              3'b101:  dec_op_s = OP_SRL;
              3'b110:  dec_op_s = OP_OR;
              3'b111:  dec_op_s = OP_AND;
              default: dec_op_s = OP_ILL;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000:  dec_op_s = OP_SUB;
              3'b101:  dec_op_s = OP_SRA;
              default: dec_op_s = OP_ILL;
            endcase
          end
          7'b0000001: begin
            case (funct3)
              3'b000:  dec_op_s = OP_MUL;
              3'b011:  dec_op_s = OP_MULHU;
`ifdef ALU_DIV_EN
              3'b101:  dec_op_s = OP_DIVU;
              3'b111:  dec_op_s = OP_REMU;
`endif
              default: dec_op_s = OP_ILL;
            endcase
          end
          default: dec_op_s = OP_ILL;
        endcase
      end
      2'b11: begin
        case (funct3)
          3'b000: dec_op_s = OP_ADD;
          3'b001: begin
            if (funct7 == 7'b0000000) dec_op_s = OP_SLL;
            else                      dec_op_s = OP_ILL;
          end
          3'b010: dec_op_s = OP_SLT;
          3'b011: dec_op_s = OP_SLTU;
          3'b100: dec_op_s = OP_XOR;
          3'b101: begin
            if (funct7[5]) dec_op_s = OP_SRA;
            else           dec_op_s = OP_SRL;
          end
          3'b110: dec_op_s = OP_OR;
          3'b111: dec_op_s = OP_AND;
          default: dec_op_s = OP_ILL;
        endcase
      end
      default: dec_op_s = OP_ILL;
    endcase
  end

  // Single-cycle result, including the divide-by-zero shortcuts
  always_comb begin
    shamt_s   = op_b[SHW-1:0];
    alu_res_s = {XLEN{1'b0}};
    case (dec_op_s)
      OP_ADD:  alu_res_s = op_a + op_b;
      OP_SUB:  alu_res_s = op_a - op_b;
      OP_SLL:  alu_res_s = op_a << shamt_s;
      OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  alu_res_s = op_a ^ op_b;
      OP_SRL:  alu_res_s = op_a >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(op_a) >>> shamt_s);
      OP_OR:   alu_res_s = op_a | op_b;
      OP_AND:  alu_res_s = op_a & op_b;
      OP_DIVU: alu_res_s = {XLEN{1'b1}};
      OP_REMU: alu_res_s = op_a;
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // Accept qualification and routing between single-cycle and iterative paths
  always_comb begin
    accept_s  = in_valid && (state_r == ST_IDLE);
    is_mul_s  = (dec_op_s == OP_MUL) || (dec_op_s == OP_MULHU);
    is_div_s  = (dec_op_s == OP_DIVU) || (dec_op_s == OP_REMU);
    div0_s    = is_div_s && (op_b == {XLEN{1'b0}});
    is_iter_s = is_mul_s || (is_div_s && !div0_s);
  end

  // One iteration: shift-add multiply or restoring divide on the shared work register
  always_comb begin
    mul_sum_s  = {1'b0, wk_r[2*XLEN-1:XLEN]} +
                 (wk_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    mul_step_s = {mul_sum_s, wk_r[XLEN-1:1]};
`ifdef ALU_DIV_EN
    div_sh_s   = wk_r[2*XLEN-1:XLEN-1];
    div_diff_s = div_sh_s - {1'b0, opnd_r};
    if (!div_diff_s[XLEN]) begin
      div_step_s = {div_diff_s[XLEN-1:0], wk_r[XLEN-2:0], 1'b1};
    end else begin
      div_step_s = {div_sh_s[XLEN-1:0], wk_r[XLEN-2:0], 1'b0};
    end
    if ((op_r == OP_MUL) || (op_r == OP_MULHU)) wk_nx_s = mul_step_s;
    else                                         wk_nx_s = div_step_s;
`else
    wk_nx_s = mul_step_s;
`endif
    if ((op_r == OP_MUL) || (op_r == OP_DIVU)) fin_res_s = wk_nx_s[XLEN-1:0];
    else                                        fin_res_s = wk_nx_s[2*XLEN-1:XLEN];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = is_iter_s ? ST_BUSY : ST_DONE;
        else          state_nx_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (cnt_r == CNT_LAST) state_nx_s = ST_DONE;
        else                   state_nx_s = ST_BUSY;
      end
      ST_DONE: begin
        if (out_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so the flops line up with it
  always_comb begin
    in_ready_nx_s  = (state_nx_s == ST_IDLE);
    out_valid_nx_s = (state_nx_s == ST_DONE);
  end

  // Handshake output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nx_s;
      out_valid_r <= out_valid_nx_s;
    end
  end

  // Operand capture, iteration and result registers; DONE holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= OP_ADD;
      cnt_r     <= {SHW{1'b0}};
      wk_r      <= {(2*XLEN){1'b0}};
      opnd_r    <= {XLEN{1'b0}};
      result_r  <= {XLEN{1'b0}};
      zero_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r  <= dec_op_s;
            cnt_r <= {SHW{1'b0}};
            if (is_iter_s) begin
              if (is_mul_s) begin
                opnd_r <= op_a;
                wk_r   <= {{XLEN{1'b0}}, op_b};
              end else begin
                opnd_r <= op_b;
                wk_r   <= {{XLEN{1'b0}}, op_a};
              end
            end else begin
              result_r  <= alu_res_s;
              zero_r    <= (alu_res_s == {XLEN{1'b0}});
              illegal_r <= (dec_op_s == OP_ILL);
            end
          end
        end
        ST_BUSY: begin
          wk_r  <= wk_nx_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            result_r  <= fin_res_s;
            zero_r    <= (fin_res_s == {XLEN{1'b0}});
            illegal_r <= 1'b0;
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven directed vectors for alu_exec_unit (XLEN=32),
// plus hand sequences for output stall and reset during a multiply.
module tb_alu_exec_unit;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [1:0]  alu_op;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;

  int n_checks = 0;
  int n_pass   = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  ao;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input string name, input logic [1:0] ao, input logic [6:0] f7,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic z, input logic il, input int lat);
    vec_t v;
    v.name = name; v.ao = ao; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
    v.res = res; v.z = z; v.il = il; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one op and wait (bounded) for out_valid; leaves out_ready low.
  task automatic run_op(input logic [1:0] ao, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic il,
                        output int lat, output int busy);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    alu_op = ao; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    if (!in_ready) busy++;
    r = result; z = zero; il = illegal;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r, r0;
    logic        z, il;
    int          lat, busy;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct7 = 7'd0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;

    add("sub_eq",    2'b01, 7'h00, 3'b000, 32'd5,          32'd5,          32'h0000_0000, 1'b1, 1'b0, 1);
    add("sra",       2'b10, 7'h20, 3'b101, 32'h8000_0000,  32'd4,          32'hF800_0000, 1'b0, 1'b0, 1);
    add("srl",       2'b10, 7'h00, 3'b101, 32'h8000_0000,  32'd4,          32'h0800_0000, 1'b0, 1'b0, 1);
    add("add_wrap",  2'b00, 7'h00, 3'b000, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1, 1'b0, 1);
    add("r_add",     2'b10, 7'h00, 3'b000, 32'd3,          32'd4,          32'd7,         1'b0, 1'b0, 1);
    add("sll_mask",  2'b10, 7'h00, 3'b001, 32'd1,          32'h0000_003F,  32'h8000_0000, 1'b0, 1'b0, 1);
    add("slt",       2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF,  32'd1,          32'd1,         1'b0, 1'b0, 1);
    add("sltu",      2'b10, 7'h00, 3'b011, 32'hFFFF_FFFF,  32'd1,          32'd0,         1'b1, 1'b0, 1);
    add("xor",       2'b10, 7'h00, 3'b100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0, 1'b0, 1'b0, 1);
    add("or",        2'b10, 7'h00, 3'b110, 32'h0000_00F0,  32'h0000_0F00,  32'h0000_0FF0, 1'b0, 1'b0, 1);
    add("and",       2'b10, 7'h00, 3'b111, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00, 1'b0, 1'b0, 1);
    add("r_sub",     2'b10, 7'h20, 3'b000, 32'd0,          32'd1,          32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    add("ill_f7_20", 2'b10, 7'h20, 3'b001, 32'd9,          32'd9,          32'd0,         1'b1, 1'b1, 1);
    add("ill_mulh",  2'b10, 7'h01, 3'b001, 32'd9,          32'd9,          32'd0,         1'b1, 1'b1, 1);
    add("ill_f7",    2'b10, 7'h02, 3'b000, 32'd9,          32'd9,          32'd0,         1'b1, 1'b1, 1);
    add("srai",      2'b11, 7'h20, 3'b101, 32'h8000_0000,  32'h0000_0401,  32'hC000_0000, 1'b0, 1'b0, 1);
    add("srli",      2'b11, 7'h00, 3'b101, 32'h8000_0000,  32'h0000_0001,  32'h4000_0000, 1'b0, 1'b0, 1);
    add("ill_slli",  2'b11, 7'h01, 3'b001, 32'd1,          32'd1,          32'd0,         1'b1, 1'b1, 1);
    add("addi",      2'b11, 7'h20, 3'b000, 32'd10,         32'hFFFF_FFFD,  32'd7,         1'b0, 1'b0, 1);
    add("slti",      2'b11, 7'h00, 3'b010, 32'hFFFF_FFFB,  32'hFFFF_FFFD,  32'd1,         1'b0, 1'b0, 1);
    add("mul",       2'b10, 7'h01, 3'b000, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    add("mulhu",     2'b10, 7'h01, 3'b011, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 1'b0, 1'b0, 33);
    add("mul_dec",   2'b10, 7'h01, 3'b000, 32'd12345,      32'd1000,       32'h00BC_5EA8, 1'b0, 1'b0, 33);
    add("mul_zero",  2'b10, 7'h01, 3'b000, 32'd0,          32'd5,          32'd0,         1'b1, 1'b0, 33);
`ifdef ALU_DIV_EN
    add("divu",      2'b10, 7'h01, 3'b101, 32'd100,        32'd7,          32'd14,        1'b0, 1'b0, 33);
    add("remu",      2'b10, 7'h01, 3'b111, 32'd100,        32'd7,          32'd2,         1'b0, 1'b0, 33);
    add("divu_by0",  2'b10, 7'h01, 3'b101, 32'd100,        32'd0,          32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    add("remu_by0",  2'b10, 7'h01, 3'b111, 32'd100,        32'd0,          32'd100,       1'b0, 1'b0, 1);
`else
    add("divu_ill",  2'b10, 7'h01, 3'b101, 32'd100,        32'd7,          32'd0,         1'b1, 1'b1, 1);
    add("remu_ill",  2'b10, 7'h01, 3'b111, 32'd100,        32'd7,          32'd0,         1'b1, 1'b1, 1);
`endif

    // Reset state
    #12;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_zero",      64'(zero),      64'd0);
    check("rst_illegal",   64'(illegal),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].ao, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b, r, z, il, lat, busy);
      check({vecs[i].name, "_result"},  64'(r),    64'(vecs[i].res));
      check({vecs[i].name, "_zero"},    64'(z),    64'(vecs[i].z));
      check({vecs[i].name, "_illegal"}, 64'(il),   64'(vecs[i].il));
      check({vecs[i].name, "_latency"}, 64'(lat),  64'(vecs[i].lat));
      check({vecs[i].name, "_busy"},    64'(busy), 64'(vecs[i].lat));
      take_result();
      check({vecs[i].name, "_ready_after"}, 64'(in_ready), 64'd1);
    end

    // Stalled consumer: DONE holds outputs and blocks new requests
    run_op(2'b10, 7'h01, 3'b001, 32'd3, 32'd3, r0, z, il, lat, busy);
    check("stall_latency", 64'(lat), 64'd1);
    in_valid = 1'b1; alu_op = 2'b00; op_a = 32'd1; op_b = 32'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready",  64'(in_ready),  64'd0);
      check("stall_result",    64'(result),    64'd0);
      check("stall_zero",      64'(zero),      64'd1);
      check("stall_illegal",   64'(illegal),   64'd1);
    end
    in_valid = 1'b0;
    take_result();
    check("stall_released", 64'(in_ready), 64'd1);

    // Reset in the middle of a multiply
    @(negedge clk);
    alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b000; op_a = 32'hFFFF_FFFF; op_b = 32'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_mul_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    check("mid_rst_result",    64'(result),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 7'h00, 3'b000, 32'd3, 32'd4, r, z, il, lat, busy);
    check("post_rst_add_result",  64'(r),   64'd7);
    check("post_rst_add_latency", 64'(lat), 64'd1);
    take_result();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
